// File: rtl/bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bist_sequencer
// Purpose  : Scan-BIST session sequencer. Seeds the input LFSR, clears the
//            MISR, runs N_PATTERNS shift/capture loops over a CHAIN_LEN-bit
//            scan chain, flushes the final response, compares the MISR
//            signature against GOLDEN and latches a PASS/FAIL verdict.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   CHAIN_LEN  scan chain length in flops (>= 1)
//   N_PATTERNS number of shift/capture loops (>= 1)
//   SIG_W      MISR signature width
//   GOLDEN     expected signature
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      session request, sampled only in IDLE
//   i_abort      session abort (active only with BIST_ABORT_EN)
//   i_sig        current MISR signature
//   o_scan_en    scan enable / test-vector mux select
//   o_lfsr_seed  one-cycle LFSR seed-load strobe
//   o_misr_clr   one-cycle MISR clear strobe
//   o_misr_en    MISR compaction enable
//   o_busy       high in every state except IDLE
//   o_bist_end   one-cycle end-of-session pulse
//   o_pass       registered verdict: signature matched
//   o_fail       registered verdict: mismatch or abort
//   o_pat_cnt    number of completed captures
// Build option
//   BIST_ABORT_EN  when defined, i_abort ends a running session with FAIL.
// ============================================================================
module bist_sequencer #(
    parameter int              CHAIN_LEN  = 8,
    parameter int              N_PATTERNS = 100,
    parameter int              SIG_W      = 7,
    parameter logic [SIG_W-1:0] GOLDEN    = 7'h2B
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic                            i_abort,
    input  logic [SIG_W-1:0]                i_sig,
    output logic                            o_scan_en,
    output logic                            o_lfsr_seed,
    output logic                            o_misr_clr,
    output logic                            o_misr_en,
    output logic                            o_busy,
    output logic                            o_bist_end,
    output logic                            o_pass,
    output logic                            o_fail,
    output logic [$clog2(N_PATTERNS+1)-1:0] o_pat_cnt
);

    localparam int SCNT_W = $clog2(CHAIN_LEN + 1);
    localparam int PCNT_W = $clog2(N_PATTERNS + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEED    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_FLUSH   = 3'd4,
        S_COMPARE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_d;
    logic [SCNT_W-1:0]   r_shift_cnt;
    logic [PCNT_W-1:0]   r_pat_cnt;
    logic                r_pass;
    logic                r_fail;

    logic                w_last_shift;
    logic                w_last_pat;
    logic                w_abort;

    // The shift counter is shared by SHIFT and FLUSH; both leave on the
    // same terminal count so it never has to wrap.
    assign w_last_shift = (r_shift_cnt == SCNT_W'(CHAIN_LEN - 1));
    // Evaluated in CAPTURE before the increment, i.e. "new count == N".
    assign w_last_pat   = (r_pat_cnt == PCNT_W'(N_PATTERNS - 1));

`ifdef BIST_ABORT_EN
    assign w_abort = i_abort && (r_state != S_IDLE) && (r_state != S_DONE);
`else
    logic w_unused_abort;
    assign w_unused_abort = i_abort;
    assign w_abort        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state;
        o_scan_en   = 1'b0;
        o_lfsr_seed = 1'b0;
        o_misr_clr  = 1'b0;
        o_misr_en   = 1'b0;
        o_bist_end  = 1'b0;
        o_busy      = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_d = S_SEED;
                end
            end
            S_SEED: begin
                o_lfsr_seed = 1'b1;
                o_misr_clr  = 1'b1;
                w_state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                o_scan_en = 1'b1;
                o_misr_en = 1'b1;
                if (w_last_shift) begin
                    w_state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                o_misr_en = 1'b1;
                w_state_d = w_last_pat ? S_FLUSH : S_SHIFT;
            end
            S_FLUSH: begin
                o_scan_en = 1'b1;
                o_misr_en = 1'b1;
                if (w_last_shift) begin
                    w_state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_state_d = S_DONE;
            end
            S_DONE: begin
                o_bist_end = 1'b1;
                w_state_d  = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        if (w_abort) begin
            w_state_d = S_DONE;
        end
    end

    // ------------------------------------------------------------------
    // Counters and verdict
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift_cnt <= '0;
            r_pat_cnt   <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_shift_cnt <= '0;
                        r_pat_cnt   <= '0;
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                    end
                end
                S_SHIFT, S_FLUSH: begin
                    if (w_last_shift) begin
                        r_shift_cnt <= '0;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + SCNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    r_pat_cnt <= r_pat_cnt + PCNT_W'(1);
                end
                S_COMPARE: begin
                    r_pass <= (i_sig == GOLDEN);
                    r_fail <= (i_sig != GOLDEN);
                end
                default: begin
                end
            endcase

            // Abort overrides any verdict written in the same cycle.
            if (w_abort) begin
                r_pass <= 1'b0;
                r_fail <= 1'b1;
            end
        end
    end

    assign o_pass    = r_pass;
    assign o_fail    = r_fail;
    assign o_pat_cnt = r_pat_cnt;

endmodule
`default_nettype wire

// File: doc/bist_sequencer.md
# bist_sequencer

Scan-BIST session sequencer for the circuit-under-test datapath, which consists of the scan-chained CUT, the input LFSR, the MISR and the signature comparator. On START it seeds the LFSR and clears the MISR, then runs N_PATTERNS shift/capture loops over a CHAIN_LEN-bit scan chain. After the loops it flushes the last response, compares the MISR signature against GOLDEN and latches a PASS/FAIL verdict. It drives the scan-enable/test-mux select, so it owns the datapath for the whole session.

## Interface
- CHAIN_LEN, 8, scan chain length in flops; must be ≥1.
- N_PATTERNS, 100, number of shift/capture loops; must be ≥1.
- SIG_W, 7, MISR signature width.
- GOLDEN, 7'h2B, expected signature (SIG_W bits).
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  request a session; sampled only in IDLE.
- ABORT  in  1  session abort (see Configuration).
- SIG  in  SIG_W  current MISR signature.
- SCAN_EN  out  1  scan enable and test-vector mux select.
- LFSR_SEED  out  1  one-cycle LFSR seed-load strobe.
- MISR_CLR  out  1  one-cycle MISR clear strobe.
- MISR_EN  out  1  MISR compaction enable.
- BUSY  out  1  high in every state except IDLE.
- BIST_END  out  1  one-cycle end-of-session pulse.
- PASS  out  1  registered verdict: signature matched.
- FAIL  out  1  registered verdict: mismatch or abort.
- PAT_CNT  out  $clog2(N_PATTERNS+1)  number of completed captures.

## Operation
- States: IDLE, SEED, SHIFT, CAPTURE, FLUSH, COMPARE, DONE.
- IDLE: all strobes are 0. When START=1, go to SEED, clear PASS, FAIL and PAT_CNT, and clear the shift counter.
- SEED (1 cycle): LFSR_SEED=1, MISR_CLR=1. Go to SHIFT.
- SHIFT (CHAIN_LEN cycles): SCAN_EN=1, MISR_EN=1, shift counter increments. On the last count, clear the counter and go to CAPTURE.
- CAPTURE (1 cycle): SCAN_EN=0, MISR_EN=1, PAT_CNT increments. If the new PAT_CNT equals N_PATTERNS, go to FLUSH; otherwise go to SHIFT.
- FLUSH (CHAIN_LEN cycles): SCAN_EN=1, MISR_EN=1. Unloads the last response. Then go to COMPARE.
- COMPARE (1 cycle): MISR_EN=0, so SIG is stable. At the exit edge, PASS is set to (SIG==GOLDEN) and FAIL to its inverse.
- DONE (1 cycle): BIST_END=1. Go to IDLE.
- A START held high through DONE re-triggers a session from IDLE on the following edge.
- START outside IDLE is ignored.
- PASS and FAIL hold their value until the next accepted START. PAT_CNT holds at N_PATTERNS after the session.
- Counters never wrap. Each counter saturates at its terminal value, which causes the state exit.

## Timing
- Reset values: SCAN_EN=0, LFSR_SEED=0, MISR_CLR=0, MISR_EN=0, BUSY=0, BIST_END=0, PASS=0, FAIL=0, PAT_CNT=0, state=IDLE.
- RST asserted mid-session returns to IDLE immediately. No BIST_END is issued and the verdict is cleared.
- All outputs are Moore outputs, registered or decoded from the state only, with no combinational input-to-output path.
- Cycle numbering: the edge that samples START is edge 0; cycle k is the cycle that follows edge k-1 (so cycle 1 follows edge 0).
  - SEED occupies cycle 1.
  - Pattern p (0-based) shifts in cycles 2+p(L+1) through 1+p(L+1)+L, and captures in cycle 2+p(L+1)+L.
  - FLUSH follows, then COMPARE.
  - DONE (BIST_END=1, PASS/FAIL valid) occurs in cycle N(L+1)+L+3, where L=CHAIN_LEN and N=N_PATTERNS.
- BUSY is high from cycle 1 through the DONE cycle inclusive.

## Configuration
- BIST_ABORT_EN defined: ABORT=1 in any state other than IDLE or DONE forces the next state to DONE.
  - At that edge, FAIL=1 and PASS=0.
  - All strobes deassert during DONE, and BIST_END pulses in DONE as normal.
  - ABORT in IDLE or DONE has no effect.
  - If ABORT and the COMPARE exit occur together, the abort wins (FAIL=1).
- BIST_ABORT_EN undefined: the ABORT port remains but is ignored. A session can end only by completion or by RST.

## Test plan
- Reset, then CHAIN_LEN=4, N_PATTERNS=3, SIG tied to GOLDEN, START pulsed once.
  - Required: SEED strobes in cycle 1, SCAN_EN high in cycles 2–5, 7–10, 12–15 and 17–20, CAPTURE in cycles 6, 11 and 16.
  - Required: BIST_END=1 only in cycle 22, then PASS=1, FAIL=0, PAT_CNT=3.
- Same configuration with SIG=GOLDEN^1 during COMPARE. Required: FAIL=1, PASS=0 from cycle 22, held until the next START.
- START held high continuously. Required: BIST_END pulses in cycle 22, the next session's SEED occurs in cycle 24, and START pulses while BUSY=1 change nothing.
- RST asserted in cycle 9. Required: all outputs at reset values immediately and no BIST_END. A START after RST deasserts produces a full 22-cycle session.
- With BIST_ABORT_EN defined, ABORT=1 sampled at edge 12. Required: BIST_END=1 and FAIL=1 in cycle 13, IDLE in cycle 14. Without the macro, the same stimulus gives normal completion in cycle 22.
- With CHAIN_LEN=1 and N_PATTERNS=1, START. Required: BIST_END in cycle 6 (1·2+1+3) and PAT_CNT=1.
